sram_arbiter: RTL

- Shares the single-port data SRAM macro between three requesters:
  - the core data port (load/store from the EX stage);
  - the instruction-fetch port;
  - an external host/pixel loader port.
- Priority: the core data port has fixed top priority and is never stalled. Fetch and host share the remaining cycles round-robin.
- Read data returns one cycle after the access and is steered to the owner by a registered tag. The block also keeps saturating wait-cycle counters for fetch and host.

---
 rtl/sram_arbiter_if.sv | 74 +++++++
 rtl/sram_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Bundles every non-clock/reset signal of the SRAM arbiter: the three
// requester ports (core data d_*, fetch i_*, host x_*), the wait-cycle counter
// controls/outputs and the SRAM macro pins.
//   modport slave  : the arbiter's view (requests in, grants/read data out,
//                    SRAM pins out, sram_dout in)
//   modport master : the environment's view (requesters plus the SRAM macro)
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) ();
    // core data port
    logic              d_req;
    logic              d_we;
    logic [DW/8-1:0]   d_ben;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_din;
    logic [DW-1:0]     d_dout;
    // instruction fetch port
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic              i_gnt;
    logic              i_ready;
    logic [DW-1:0]     i_rdata;
    // host / pixel loader port
    logic              x_req;
    logic              x_we;
    logic [DW/8-1:0]   x_ben;
    logic [AW-1:0]     x_addr;
    logic [DW-1:0]     x_wdata;
    logic              x_gnt;
    logic              x_rvalid;
    logic [DW-1:0]     x_rdata;
    // wait-cycle counters
    logic              cnt_clr;
    logic [CNT_W-1:0]  i_wait_cnt;
    logic [CNT_W-1:0]  x_wait_cnt;
    // SRAM macro
    logic              sram_cen;
    logic              sram_wen;
    logic [DW/8-1:0]   sram_ben;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_din;
    logic [DW-1:0]     sram_dout;

    modport slave (
        input  d_req, d_we, d_ben, d_addr, d_din,
        output d_dout,
        input  i_req, i_addr,
        output i_gnt, i_ready, i_rdata,
        input  x_req, x_we, x_ben, x_addr, x_wdata,
        output x_gnt, x_rvalid, x_rdata,
        input  cnt_clr,
        output i_wait_cnt, x_wait_cnt,
        output sram_cen, sram_wen, sram_ben, sram_addr, sram_din,
        input  sram_dout
    );

    modport master (
        output d_req, d_we, d_ben, d_addr, d_din,
        input  d_dout,
        output i_req, i_addr,
        input  i_gnt, i_ready, i_rdata,
        output x_req, x_we, x_ben, x_addr, x_wdata,
        input  x_gnt, x_rvalid, x_rdata,
        output cnt_clr,
        input  i_wait_cnt, x_wait_cnt,
        input  sram_cen, sram_wen, sram_ben, sram_addr, sram_din,
        output sram_dout
    );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one single-port SRAM between the core data port (fixed top priority,
// never stalled), the instruction fetch port and a host loader port. Fetch and
// host split the remaining cycles round-robin. Read data comes back one cycle
// after the access and is steered by a registered owner tag. Saturating
// counters record how many cycles fetch and host spent waiting.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : sram_arbiter_if.slave -- requester ports, counters, SRAM pins
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);

    typedef enum logic {
        RR_I = 1'b0,
        RR_X = 1'b1
    } rr_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2,
        OWN_X    = 2'd3
    } owner_t;

    rr_t              r_rr_last;
    rr_t              w_rr_next;
    owner_t           r_rd_owner;
    owner_t           w_rd_owner_next;
    logic             w_d_own;
    logic             w_i_gnt;
    logic             w_x_gnt;
    logic [CNT_W-1:0] r_i_wait;
    logic [CNT_W-1:0] r_x_wait;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    // Ownership decision. Everything is gated by rst so the SRAM goes quiet
    // the moment reset is asserted, even mid-cycle.
    always_comb begin
        w_d_own = 1'b0;
        w_i_gnt = 1'b0;
        w_x_gnt = 1'b0;
        if (!rst) begin
            if (bus.d_req) begin
                w_d_own = 1'b1;
            end else if (bus.i_req && bus.x_req) begin
                // tie: whoever was not served last time wins
                if (r_rr_last == RR_X) w_i_gnt = 1'b1;
                else                   w_x_gnt = 1'b1;
            end else if (bus.i_req) begin
                w_i_gnt = 1'b1;
            end else if (bus.x_req) begin
                w_x_gnt = 1'b1;
            end
        end
    end

    // Next round-robin pointer and read-return tag. Writes and idle cycles
    // load NONE so no valid is raised for them.
    always_comb begin
        w_rr_next       = r_rr_last;
        w_rd_owner_next = OWN_NONE;
        if (w_i_gnt) w_rr_next = RR_I;
        if (w_x_gnt) w_rr_next = RR_X;
        if (w_d_own && !bus.d_we)       w_rd_owner_next = OWN_D;
        else if (w_i_gnt)               w_rd_owner_next = OWN_I;
        else if (w_x_gnt && !bus.x_we)  w_rd_owner_next = OWN_X;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last  <= RR_X;
            r_rd_owner <= OWN_NONE;
        end else begin
            r_rr_last  <= w_rr_next;
            r_rd_owner <= w_rd_owner_next;
        end
    end

    // Wait counters: clear beats increment; a request counts as waiting in
    // any cycle it is not granted, including cycles taken by the data port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_wait <= '0;
            r_x_wait <= '0;
        end else if (bus.cnt_clr) begin
            r_i_wait <= '0;
            r_x_wait <= '0;
        end else begin
            if (bus.i_req && !w_i_gnt) r_i_wait <= sat_inc(r_i_wait);
            if (bus.x_req && !w_x_gnt) r_x_wait <= sat_inc(r_x_wait);
        end
    end

    // SRAM pin drive, idle values first
    always_comb begin
        bus.sram_cen  = 1'b1;
        bus.sram_wen  = 1'b1;
        bus.sram_ben  = '1;
        bus.sram_addr = '0;
        bus.sram_din  = '0;
        if (w_d_own) begin
            bus.sram_cen  = 1'b0;
            bus.sram_wen  = !bus.d_we;
            bus.sram_ben  = bus.d_ben;
            bus.sram_addr = bus.d_addr;
            bus.sram_din  = bus.d_din;
        end else if (w_i_gnt) begin
            bus.sram_cen  = 1'b0;
            bus.sram_ben  = '0;
            bus.sram_addr = bus.i_addr;
        end else if (w_x_gnt) begin
            bus.sram_cen  = 1'b0;
            bus.sram_wen  = !bus.x_we;
            bus.sram_ben  = bus.x_ben;
            bus.sram_addr = bus.x_addr;
            bus.sram_din  = bus.x_wdata;
        end
    end

    assign bus.i_gnt      = w_i_gnt;
    assign bus.x_gnt      = w_x_gnt;
    assign bus.d_dout     = bus.sram_dout;
    assign bus.i_ready    = (r_rd_owner == OWN_I);
    assign bus.x_rvalid   = (r_rd_owner == OWN_X);
    assign bus.i_rdata    = (r_rd_owner == OWN_I) ? bus.sram_dout : '0;
    assign bus.x_rdata    = (r_rd_owner == OWN_X) ? bus.sram_dout : '0;
    assign bus.i_wait_cnt = r_i_wait;
    assign bus.x_wait_cnt = r_x_wait;

endmodule
